// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register family (usr, usr_deserializer).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package usr_pkg;

    // Receiver control states
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Shift direction, same encoding as the usr shf control
    localparam logic DIR_LEFT  = 1'b0;  // MSB-first: first bit ends in y[WIDTH-1]
    localparam logic DIR_RIGHT = 1'b1;  // LSB-first: first bit ends in y[0]

endpackage

// File: rtl/usr_deserializer_if.sv
// Serial-in / word-out bus between the link capture logic and its consumer.
// Latency: n/a (signal bundle only).
// Backpressure: y_ready from the consumer stalls the word output.
interface usr_deserializer_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sin_valid;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic             y_ready;

    // Deserializer side: consumes serial bits, produces words
    modport master (
        input  sin,
        input  sin_valid,
        output y,
        output y_valid,
        input  y_ready
    );

    // Link/consumer side: drives serial bits, accepts words
    modport slave (
        output sin,
        output sin_valid,
        input  y,
        input  y_valid,
        output y_ready
    );
endinterface

// File: rtl/usr_out_stage.sv
// WIDTH-bit valid/ready holding register with sticky overrun on dropped words.
// Latency: word appears on y one cycle after load.
// Backpressure: a load while holding an unaccepted word drops the new word and sets overrun.
module usr_out_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             y_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic             overrun
);

    // Hold the word until accepted; a load with the slot free or draining this edge replaces it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y       <= '0;
            y_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (clr) begin
                overrun <= 1'b0;
            end
            if (load) begin
                if (!y_valid || y_ready) begin
                    y       <= word;
                    y_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (y_valid && y_ready) begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/usr_deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH sampled bits (MSB- or LSB-first) into a word.
// Latency: word valid on y the cycle after the edge that samples its last bit.
// Backpressure: none on the serial side; words completing while the output is stalled are dropped (overrun).
module usr_deserializer
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               dir,
    usr_deserializer_if.master bus,
    output logic               busy,
    output logic               overrun
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic             dir_q;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    count;
    logic             sample;
    logic             last;
    logic             done;

    // A bit is taken only in SHIFT, never on a start/abort cycle
    assign sample = (state == SHIFT) && bus.sin_valid && !abort && !start;
    assign last   = (count == CW'(WIDTH - 1));
    assign done   = sample && last;

    // Shift register contents after absorbing the current serial bit
    always_comb begin
        sr_next = sr;
        if (dir_q == DIR_LEFT) begin
            sr_next = {sr[WIDTH-2:0], bus.sin};
        end else begin
            sr_next = {bus.sin, sr[WIDTH-1:1]};
        end
    end

    // Control FSM, shift register and bit counter; abort has priority over start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            dir_q <= DIR_LEFT;
            sr    <= '0;
            count <= '0;
        end else if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            sr    <= '0;
            count <= '0;
        end else if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
            dir_q <= dir;
            sr    <= '0;
            count <= '0;
        end else if (sample) begin
            sr    <= sr_next;
            count <= last ? '0 : count + 1'b1;
        end
    end

    // Completed words go through the registered handshake stage
    usr_out_stage #(
        .WIDTH (WIDTH)
    ) u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start && !abort),
        .load    (done),
        .word    (sr_next),
        .y_ready (bus.y_ready),
        .y       (bus.y),
        .y_valid (bus.y_valid),
        .overrun (overrun)
    );

endmodule

// File: tb/tb_usr_deserializer.sv
// Directed bench for usr_deserializer (WIDTH=4) with a bit-queue reference model.
// Outputs are compared against the model on every falling edge, plus literal spot checks.
module tb_usr_deserializer;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, dir = 1'b0;
    logic busy, overrun;
    int   n_tests = 0;
    int   n_fail  = 0;

    usr_deserializer_if #(.WIDTH(W)) bus ();

    usr_deserializer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .dir     (dir),
        .bus     (bus),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collects sampled bits in a queue and places them by index on completion
    logic         m_busy, m_dir, m_vld, m_ovr;
    logic [W-1:0] m_y, m_w;
    logic         m_q[$];
    logic         m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_dir = 0; m_vld = 0; m_ovr = 0; m_y = '0;
            m_q.delete();
        end else begin
            m_done = 0;
            if (abort) begin
                m_busy = 0;
                m_q.delete();
            end else if (start) begin
                m_busy = 1; m_dir = dir; m_ovr = 0;
                m_q.delete();
            end else if (m_busy && bus.sin_valid) begin
                m_q.push_back(bus.sin);
                if (m_q.size() == W) begin
                    for (int i = 0; i < W; i++) begin
                        if (m_dir == 1'b0) m_w[W-1-i] = m_q[i];
                        else               m_w[i]     = m_q[i];
                    end
                    m_done = 1;
                    m_q.delete();
                end
            end
            if (m_done) begin
                if (!m_vld || bus.y_ready) begin
                    m_y = m_w; m_vld = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_vld && bus.y_ready) begin
                m_vld = 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        check("cyc_y",       32'(bus.y),       32'(m_y));
        check("cyc_y_valid", 32'(bus.y_valid), 32'(m_vld));
        check("cyc_busy",    32'(busy),        32'(m_busy));
        check("cyc_overrun", 32'(overrun),     32'(m_ovr));
    end

    task automatic drive(input logic st, input logic ab, input logic d,
                         input logic s, input logic sv, input logic rdy);
        @(negedge clk);
        start = st; abort = ab; dir = d;
        bus.sin = s; bus.sin_valid = sv; bus.y_ready = rdy;
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] bits, input logic d, input logic rdy);
        for (int i = W - 1; i >= 0; i--) drive(0, 0, d, bits[i], 1, rdy);
    endtask

    int vld_cnt;
    int last_pos;
    int pos;

    initial begin
        bus.sin = 0; bus.sin_valid = 0; bus.y_ready = 1;
        #2;
        check("reset_y",    32'(bus.y),       0);
        check("reset_vld",  32'(bus.y_valid), 0);
        check("reset_busy", 32'(busy),        0);
        check("reset_ovr",  32'(overrun),     0);
        @(negedge clk); rst_n = 1;

        // MSB-first
        drive(1, 0, 0, 0, 0, 1);
        send_word(4'b1011, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        check("msb_y",   32'(bus.y),       32'b1011);
        check("msb_vld", 32'(bus.y_valid), 1);
        check("msb_ovr", 32'(overrun),     0);

        // LSB-first: first bit lands in y[0]
        drive(1, 0, 1, 0, 0, 1);
        send_word(4'b1011, 1, 1);
        drive(0, 0, 1, 0, 0, 1);
        check("lsb_y", 32'(bus.y), 32'b1101);

        // Stalled consumer: second word is dropped
        drive(1, 0, 0, 0, 0, 0);
        send_word(4'b1011, 0, 0);
        send_word(4'b0110, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("ovr_y",   32'(bus.y),   32'b1011);
        check("ovr_set", 32'(overrun), 1);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        check("ovr_clr", 32'(overrun), 0);
        drive(0, 0, 0, 0, 0, 1);

        // Continuous stream of three words
        drive(1, 0, 0, 0, 0, 1);
        vld_cnt = 0; last_pos = -1; pos = 0;
        for (int k = 0; k < 3 * W + 2; k++) begin
            logic [3*W-1:0] stream;
            stream = 12'b1011_0110_1100;
            if (k < 3 * W) drive(0, 0, 0, stream[3*W-1-k], 1, 1);
            else           drive(0, 0, 0, 0, 0, 1);
            pos++;
            if (bus.y_valid) begin
                if (last_pos >= 0) check("stream_gap", 32'(pos - last_pos), W);
                last_pos = pos;
                vld_cnt++;
            end
        end
        check("stream_words", 32'(vld_cnt), 3);
        check("stream_ovr",   32'(overrun), 0);
        check("stream_last",  32'(bus.y),   32'b1100);

        // Abort mid-word, then a fresh word with no residue
        drive(1, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 1, 1);
        drive(0, 0, 0, 1, 1, 1);
        drive(0, 1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        check("abort_busy", 32'(busy), 0);
        drive(1, 0, 0, 0, 0, 1);
        send_word(4'b0101, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        check("abort_y", 32'(bus.y), 32'b0101);

        // Asynchronous reset mid-word
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 1, 1, 0);
        #1 rst_n = 0;
        #1;
        check("arst_y",    32'(bus.y),       0);
        check("arst_vld",  32'(bus.y_valid), 0);
        check("arst_busy", 32'(busy),        0);
        check("arst_ovr",  32'(overrun),     0);
        @(negedge clk); rst_n = 1;
        drive(1, 0, 0, 0, 0, 1);
        send_word(4'b1110, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        check("arst_word", 32'(bus.y), 32'b1110);

        // dir toggling and sin_valid gaps mid-word
        drive(1, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 1, 1, 1);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 1, 1);
        drive(0, 0, 1, 1, 0, 1);
        drive(0, 0, 0, 1, 1, 1);
        drive(0, 0, 1, 0, 0, 1);
        drive(0, 0, 1, 1, 1, 1);
        drive(0, 0, 0, 0, 0, 1);
        check("gap_y",   32'(bus.y),       32'b1011);
        check("gap_vld", 32'(bus.y_valid), 1);

        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/usr_deserializer.md
# usr_deserializer

Serial-in/parallel-out receiver paired with the universal shift register (`usr`). It assembles a serial bit stream into WIDTH-bit words in either shift direction. Completed words go out through a registered valid/ready output stage. It sits at the capture end of a link whose far end is driven by `usr` shifting data out, and it reports overrun when the consumer stalls.

## Interface
Parameters:
- WIDTH, 4, word width in bits (≥2)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin reception, latch dir, clear count and overrun
- abort  in  1  pulse: return to IDLE, discard partial word
- dir  in  1  0 = shift-left/MSB-first (first bit ends in y[WIDTH-1]); 1 = shift-right/LSB-first (first bit ends in y[0])
- sin  in  1  serial data bit
- sin_valid  in  1  sin is sampled this cycle
- y  out  WIDTH  assembled word
- y_valid  out  1  y holds an unconsumed word
- y_ready  in  1  consumer accepts y
- busy  out  1  in SHIFT state
- overrun  out  1  sticky: a completed word was dropped

## Operation
- States: IDLE, SHIFT.
- IDLE → SHIFT on start. In IDLE, sin_valid is ignored.
- SHIFT → IDLE on abort. abort wins over a simultaneous start.
- start while in SHIFT restarts the word: count ← 0 and the partial word is discarded. The output stage (y, y_valid) is not touched.
- dir is latched into dir_q on start. Changes to dir during SHIFT have no effect.
- The bit on a start cycle is not sampled. The first bit is sampled on a later cycle with sin_valid=1.
- On each sampled bit in SHIFT:
  - dir_q=0: sr ← {sr[WIDTH-2:0], sin}
  - dir_q=1: sr ← {sin, sr[WIDTH-1:1]}
  - count increments.
- The counter is $clog2(WIDTH) bits wide and wraps from WIDTH-1 to 0.
- Completion is the edge that samples the WIDTH-th bit. On that edge the assembled word, including that bit, is routed to the output stage and count ← 0. The FSM stays in SHIFT (continuous reception).
- Output stage at a completion edge:
  - y_valid=0 or y_ready=1: y ← word, y_valid ← 1.
  - y_valid=1 and y_ready=0: the word is dropped, y is unchanged, overrun ← 1.
- Output stage without completion: y_valid && y_ready clears y_valid.
- overrun is cleared only by start or reset.
- Reset values: y=0, y_valid=0, busy=0, overrun=0, sr=0, count=0, state=IDLE, dir_q=0.
- Reset asserted mid-word discards everything immediately, asynchronously.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Latency: y_valid is high and y is valid in the cycle after the edge that samples the last bit.
- Maximum throughput is one word per WIDTH cycles with sin_valid held at 1. Back-to-back words need no gap.
- Handshake: a transfer occurs on an edge with y_valid=1 and y_ready=1. y is stable while y_valid=1 and y_ready=0.
- Completion and a transfer on the same edge: the new word loads, y_valid stays 1, and overrun is not set.
- busy rises the cycle after start and falls the cycle after abort.

## Structure
- Shared package usr_pkg holds:
  - the state enum (IDLE, SHIFT)
  - direction constants DIR_LEFT=1'b0 and DIR_RIGHT=1'b1, shared with the usr shf encoding
- One sub-module, usr_out_stage, is natural. It is a WIDTH-bit valid/ready holding register with overrun detection.
- The FSM, shift register and counter stay in the top level.

## Test plan
- WIDTH=4, dir=0, start, then bits 1,0,1,1 with sin_valid=1 → one cycle after the 4th bit, y=4'b1011, y_valid=1, overrun=0.
- dir=1, same bits 1,0,1,1 → y=4'b1101.
- y_ready=0, stream two words (1011, then 0110) → y stays 1011 and overrun=1 after the 8th bit. A later start clears overrun.
- y_ready=1, 12 continuous bits → three words, with y_valid pulses spaced 4 cycles apart and no overrun.
- Two bits in, then abort → busy=0, y_valid unchanged. After start, 4 new bits produce a word with no residue from the aborted bits.
- rst_n low after 3 bits → all outputs 0 asynchronously. After release and start, 4 bits give the correct word.
- Toggle dir and sin_valid gaps mid-word → dir ignored, bits sampled only on sin_valid=1, result unchanged.
